// File: rtl/dram_pkg.sv
// Shared types, timing defaults and byte-lane decode for the FPM DRAM controller.
package dram_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_RAS    = 3'd1,
    ST_COL    = 3'd2,
    ST_CAS    = 3'd3,
    ST_ACK    = 3'd4,
    ST_PRE    = 3'd5,
    ST_RF_CAS = 3'd6,
    ST_RF_RAS = 3'd7
  } dram_state_e;

  localparam int DEF_ROW_BITS    = 11;
  localparam int DEF_COL_BITS    = 11;
  localparam int DEF_REFRESH_DIV = 780;
  localparam int DEF_T_RCD       = 1;
  localparam int DEF_T_CAS       = 2;
  localparam int DEF_T_RAS_RF    = 3;
  localparam int DEF_T_RP        = 3;

  // Width of the shared phase counter; every timing parameter must fit below 2**CNT_W.
  localparam int CNT_W = 4;

  // Active-low CAS mask for a 32-bit port; bit i is lane i, lane 0 = D31:24.
  // A write enables lanes A[1:0] .. A[1:0]+n-1 clipped at lane 3 (n = 4 for SIZ=00).
  function automatic logic [3:0] lane_mask(input logic [1:0] siz,
                                           input logic [1:0] a,
                                           input logic       rnw);
    logic [2:0] n_s;
    logic [2:0] lo_s;
    logic [2:0] hi_s;
    logic [3:0] m_s;
    n_s  = (siz == 2'b00) ? 3'd4 : {1'b0, siz};
    lo_s = {1'b0, a};
    hi_s = lo_s + n_s;
    m_s  = 4'b1111;
    for (int i = 0; i < 4; i++) begin
      if (rnw) begin
        m_s[i] = 1'b0;
      end else if ((3'(i) >= lo_s) && (3'(i) < hi_s)) begin
        m_s[i] = 1'b0;
      end else begin
        m_s[i] = 1'b1;
      end
    end
    return m_s;
  endfunction

endpackage

// File: rtl/dram_ctl_if.sv
// CPU-side strobes in, DRAM strobes and termination out, bundled for the controller.
interface dram_ctl_if
  import dram_pkg::*;
#(
  parameter int ROW_BITS = DEF_ROW_BITS,
  parameter int COL_BITS = DEF_COL_BITS
);
  localparam int MA_W   = (ROW_BITS > COL_BITS) ? ROW_BITS : COL_BITS;
  localparam int ADDR_W = ROW_BITS + COL_BITS + 3;

  logic              nRAMSEL;
  logic              nAS;
  logic              nDS;
  logic              RnW;
  logic [1:0]        SIZ;
  logic [ADDR_W-1:0] ADDR;
  logic [MA_W-1:0]   MA;
  logic [1:0]        nRAS;
  logic [3:0]        nCAS;
  logic              nWE;
  logic [1:0]        nDSACK;

  modport master (
    output nRAMSEL, nAS, nDS, RnW, SIZ, ADDR,
    input  MA, nRAS, nCAS, nWE, nDSACK
  );

  modport slave (
    input  nRAMSEL, nAS, nDS, RnW, SIZ, ADDR,
    output MA, nRAS, nCAS, nWE, nDSACK
  );

endinterface

// File: rtl/dram_refresh_timer.sv
// Free-running refresh interval counter raising a sticky request until the controller clears it.
module dram_refresh_timer
  import dram_pkg::*;
#(
  parameter int REFRESH_DIV = DEF_REFRESH_DIV
) (
  input  logic DRAM_CLK,
  input  logic nRST,
  input  logic clr_i,
  output logic pend_o
);

  localparam int            CW     = $clog2(REFRESH_DIV);
  localparam logic [CW-1:0] RELOAD = CW'(REFRESH_DIV - 1);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;
  logic          pend_q;
  logic          pend_d;

  // Next count and request; a tick outranks a same-cycle clear so no request is lost.
  always_comb begin
    cnt_d  = cnt_q;
    pend_d = pend_q;
    if (cnt_q == {CW{1'b0}}) begin
      cnt_d  = RELOAD;
      pend_d = 1'b1;
    end else begin
      cnt_d  = cnt_q - CW'(1);
      pend_d = pend_q & ~clr_i;
    end
  end

  // Counter and request registers.
  always_ff @(posedge DRAM_CLK or negedge nRST) begin
    if (!nRST) begin
      cnt_q  <= RELOAD;
      pend_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      pend_q <= pend_d;
    end
  end

  assign pend_o = pend_q;

endmodule

// File: rtl/dram_ctl.sv
// FPM DRAM controller: RAS/CAS/WE sequencing, row/column muxing, DSACK termination, CBR refresh.
// Define DRAM_BANK2_EN to decode ADDR[24] onto nRAS[1]; otherwise only bank 0 is accessed.
module dram_ctl
  import dram_pkg::*;
#(
  parameter int ROW_BITS    = DEF_ROW_BITS,
  parameter int COL_BITS    = DEF_COL_BITS,
  parameter int REFRESH_DIV = DEF_REFRESH_DIV,
  parameter int T_RCD       = DEF_T_RCD,
  parameter int T_CAS       = DEF_T_CAS,
  parameter int T_RAS_RF    = DEF_T_RAS_RF,
  parameter int T_RP        = DEF_T_RP
) (
  input logic       DRAM_CLK,
  input logic       nRST,
  dram_ctl_if.slave bus
);

  localparam int MA_W     = (ROW_BITS > COL_BITS) ? ROW_BITS : COL_BITS;
  localparam int BANK_BIT = ROW_BITS + COL_BITS + 2;

  dram_state_e      state_q;
  dram_state_e      state_d;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic [MA_W-1:0]  ma_q;
  logic [MA_W-1:0]  ma_d;
  logic [1:0]       nras_q;
  logic [1:0]       nras_d;
  logic [3:0]       ncas_q;
  logic [3:0]       ncas_d;
  logic             nwe_q;
  logic             nwe_d;
  logic [1:0]       ndsack_q;
  logic [1:0]       ndsack_d;

  logic             rf_pend_s;
  logic             rf_clr_s;
  logic             release_s;
  logic [MA_W-1:0]  row_s;
  logic [MA_W-1:0]  col_s;
  logic [1:0]       bank_ras_s;

  dram_refresh_timer #(
    .REFRESH_DIV (REFRESH_DIV)
  ) u_refresh (
    .DRAM_CLK (DRAM_CLK),
    .nRST     (nRST),
    .clr_i    (rf_clr_s),
    .pend_o   (rf_pend_s)
  );

  assign row_s = MA_W'(bus.ADDR[COL_BITS+ROW_BITS+1:COL_BITS+2]);
  assign col_s = MA_W'(bus.ADDR[COL_BITS+1:2]);

`ifdef DRAM_BANK2_EN
  assign bank_ras_s = bus.ADDR[BANK_BIT] ? 2'b01 : 2'b10;
`else
  // Without the second bank the top address bit is a don't-care, so memory aliases.
  logic unused_bank_s;
  assign bank_ras_s    = 2'b10;
  assign unused_bank_s = bus.ADDR[BANK_BIT];
`endif

  // Sequencer: strobes change only here; release_s funnels every exit into precharge.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    ma_d      = ma_q;
    nras_d    = nras_q;
    ncas_d    = ncas_q;
    nwe_d     = nwe_q;
    ndsack_d  = ndsack_q;
    rf_clr_s  = 1'b0;
    release_s = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (rf_pend_s) begin
          state_d  = ST_RF_CAS;
          ncas_d   = 4'b0000;
          nwe_d    = 1'b1;
          rf_clr_s = 1'b1;
        end else if (!bus.nRAMSEL && !bus.nAS) begin
          state_d = ST_RAS;
          ma_d    = row_s;
          nras_d  = bank_ras_s;
          nwe_d   = bus.RnW;
          cnt_d   = CNT_W'(T_RCD - 1);
        end else begin
          state_d = ST_IDLE;
        end
      end

      ST_RAS: begin
        if (bus.nAS) begin
          release_s = 1'b1;
        end else if (cnt_q == {CNT_W{1'b0}}) begin
          state_d = ST_COL;
          ma_d    = col_s;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end

      // Writes hold off CAS until the CPU has valid data (nDS low).
      ST_COL: begin
        if (bus.nAS) begin
          release_s = 1'b1;
        end else if (bus.RnW || !bus.nDS) begin
          state_d = ST_CAS;
          ncas_d  = lane_mask(bus.SIZ, bus.ADDR[1:0], bus.RnW);
          cnt_d   = CNT_W'(T_CAS - 1);
        end else begin
          state_d = ST_COL;
        end
      end

      ST_CAS: begin
        if (bus.nAS) begin
          release_s = 1'b1;
        end else if (cnt_q == {CNT_W{1'b0}}) begin
          state_d  = ST_ACK;
          ndsack_d = 2'b00;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end

      ST_ACK: begin
        if (bus.nAS) begin
          release_s = 1'b1;
        end else begin
          state_d = ST_ACK;
        end
      end

      ST_PRE: begin
        if (cnt_q == {CNT_W{1'b0}}) begin
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end

      ST_RF_CAS: begin
        state_d = ST_RF_RAS;
        nras_d  = 2'b00;
        cnt_d   = CNT_W'(T_RAS_RF - 1);
      end

      ST_RF_RAS: begin
        if (cnt_q == {CNT_W{1'b0}}) begin
          release_s = 1'b1;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end

      default: begin
        release_s = 1'b1;
      end
    endcase

    if (release_s) begin
      state_d  = ST_PRE;
      cnt_d    = CNT_W'(T_RP - 1);
      nras_d   = 2'b11;
      ncas_d   = 4'b1111;
      nwe_d    = 1'b1;
      ndsack_d = 2'b11;
    end else begin
      state_d = state_d;
    end
  end

  // State and output registers; reset drops every strobe at once.
  always_ff @(posedge DRAM_CLK or negedge nRST) begin
    if (!nRST) begin
      state_q  <= ST_IDLE;
      cnt_q    <= {CNT_W{1'b0}};
      ma_q     <= {MA_W{1'b0}};
      nras_q   <= 2'b11;
      ncas_q   <= 4'b1111;
      nwe_q    <= 1'b1;
      ndsack_q <= 2'b11;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      ma_q     <= ma_d;
      nras_q   <= nras_d;
      ncas_q   <= ncas_d;
      nwe_q    <= nwe_d;
      ndsack_q <= ndsack_d;
    end
  end

  assign bus.MA     = ma_q;
  assign bus.nRAS   = nras_q;
  assign bus.nCAS   = ncas_q;
  assign bus.nWE    = nwe_q;
  assign bus.nDSACK = ndsack_q;

endmodule

// File: tb/tb_dram_ctl.sv
// Directed bench for dram_ctl: table of accesses plus refresh, abort, and reset sequences.
module tb_dram_ctl;

  typedef struct {
    string       name;
    logic        rnw;
    logic [1:0]  siz;
    logic [24:0] addr;
    logic [10:0] row;
    logic [10:0] col;
    logic [3:0]  ncas;
    logic [1:0]  nras;
  } vec_t;

`ifdef DRAM_BANK2_EN
  localparam logic [1:0] BANK1_RAS = 2'b01;
`else
  localparam logic [1:0] BANK1_RAS = 2'b10;
`endif

  logic DRAM_CLK = 1'b0;
  logic nRST     = 1'b1;
  int   cyc      = 0;
  int   checks   = 0;
  int   failures = 0;
  vec_t tbl [7];

  dram_ctl_if bus ();

  dram_ctl dut (
    .DRAM_CLK (DRAM_CLK),
    .nRST     (nRST),
    .bus      (bus)
  );

  always #10 DRAM_CLK = ~DRAM_CLK;

  // Edge count since the last reset release; refresh requests land on multiples of 780.
  always @(posedge DRAM_CLK or negedge nRST) begin
    if (!nRST) cyc <= 0;
    else       cyc <= cyc + 1;
  end

  task automatic chk_core(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (cyc %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic chk1(input string nm, input logic a, input logic e);
    chk_core(nm, 32'(a), 32'(e));
  endtask

  task automatic chk2(input string nm, input logic [1:0] a, input logic [1:0] e);
    chk_core(nm, 32'(a), 32'(e));
  endtask

  task automatic chk4(input string nm, input logic [3:0] a, input logic [3:0] e);
    chk_core(nm, 32'(a), 32'(e));
  endtask

  task automatic chk11(input string nm, input logic [10:0] a, input logic [10:0] e);
    chk_core(nm, 32'(a), 32'(e));
  endtask

  task automatic tick;
    @(posedge DRAM_CLK);
    #2;
  endtask

  task automatic idle_bus;
    bus.nRAMSEL = 1'b1;
    bus.nAS     = 1'b1;
    bus.nDS     = 1'b1;
  endtask

  task automatic start_read(input logic [24:0] a);
    bus.ADDR    = a;
    bus.SIZ     = 2'b00;
    bus.RnW     = 1'b1;
    bus.nRAMSEL = 1'b0;
    bus.nAS     = 1'b0;
    bus.nDS     = 1'b0;
  endtask

  task automatic chk_released(input string nm);
    chk2({nm, ":nras"}, bus.nRAS, 2'b11);
    chk4({nm, ":ncas"}, bus.nCAS, 4'b1111);
    chk1({nm, ":nwe"}, bus.nWE, 1'b1);
    chk2({nm, ":dsack"}, bus.nDSACK, 2'b11);
  endtask

  // One complete CPU cycle, checked phase by phase; returns just after the release edge.
  task automatic do_access(input vec_t v);
    bus.ADDR    = v.addr;
    bus.SIZ     = v.siz;
    bus.RnW     = v.rnw;
    bus.nRAMSEL = 1'b0;
    bus.nAS     = 1'b0;
    bus.nDS     = v.rnw ? 1'b0 : 1'b1;
    tick;
    chk2({v.name, ":ras"}, bus.nRAS, v.nras);
    chk11({v.name, ":row"}, bus.MA, v.row);
    chk1({v.name, ":we"}, bus.nWE, v.rnw);
    chk4({v.name, ":cas_off"}, bus.nCAS, 4'b1111);
    tick;
    chk11({v.name, ":col"}, bus.MA, v.col);
    chk4({v.name, ":cas_rcd"}, bus.nCAS, 4'b1111);
    if (!v.rnw) begin
      tick;
      chk4({v.name, ":cas_wait_ds"}, bus.nCAS, 4'b1111);
      bus.nDS = 1'b0;
    end
    tick;
    chk4({v.name, ":cas"}, bus.nCAS, v.ncas);
    chk1({v.name, ":we_cas"}, bus.nWE, v.rnw);
    tick;
    chk2({v.name, ":dsack_early"}, bus.nDSACK, 2'b11);
    tick;
    chk2({v.name, ":dsack"}, bus.nDSACK, 2'b00);
    tick;
    chk2({v.name, ":dsack_hold"}, bus.nDSACK, 2'b00);
    chk2({v.name, ":ras_hold"}, bus.nRAS, v.nras);
    idle_bus;
    tick;
    chk_released({v.name, ":rel"});
  endtask

  task automatic wait_cyc(input int target);
    int g;
    g = 0;
    while (cyc < target && g < 3000) begin
      tick;
      g++;
    end
    chk1("wait_cyc_reached", (cyc == target), 1'b1);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    int gap;
    logic gap_ok;

    // Lane masks: bit i is lane i (lane 0 = D31:24), active low.
    tbl[0] = '{"rd_long_1004", 1'b1, 2'b00, 25'h000_1004, 11'h000, 11'h401, 4'b0000, 2'b10};
    tbl[1] = '{"wr_byte_0002", 1'b0, 2'b01, 25'h000_0002, 11'h000, 11'h000, 4'b1011, 2'b10};
    tbl[2] = '{"wr_word_a01",  1'b0, 2'b10, 25'h012_3459, 11'h091, 11'h516, 4'b1001, 2'b10};
    tbl[3] = '{"wr_3b_top",    1'b0, 2'b11, 25'h0FF_FFFE, 11'h7FF, 11'h7FF, 4'b0011, 2'b10};
    tbl[4] = '{"wr_long_8000", 1'b0, 2'b00, 25'h000_8000, 11'h004, 11'h000, 4'b0000, 2'b10};
    tbl[5] = '{"rd_bank_bit",  1'b1, 2'b00, 25'h100_0000, 11'h000, 11'h000, 4'b0000, BANK1_RAS};
    tbl[6] = '{"wr_byte_a11",  1'b0, 2'b01, 25'h000_0003, 11'h000, 11'h000, 4'b0111, 2'b10};

    bus.ADDR = 25'h0;
    bus.SIZ  = 2'b00;
    bus.RnW  = 1'b1;
    idle_bus;

    #1 nRST = 1'b0;
    #4;
    chk_released("reset_async");
    chk11("reset_ma", bus.MA, 11'h000);
    @(negedge DRAM_CLK);
    nRST = 1'b1;
    tick;

    for (int i = 0; i < 7; i++) begin
      do_access(tbl[i]);
      repeat (3) tick;
    end

    // Back-to-back request during precharge: delayed, never dropped.
    do_access(tbl[0]);
    start_read(25'h000_1004);
    gap = 0;
    for (int k = 0; k < 20; k++) begin
      tick;
      gap++;
      if (bus.nRAS != 2'b11) break;
    end
    gap_ok = (gap >= 3) && (gap < 20);
    chk1("pre_gap_min3", gap_ok, 1'b1);
    chk2("pre_delayed_ras", bus.nRAS, 2'b10);

    // Abort while CAS is asserted: no DSACK, strobes release, back to idle after precharge.
    tick;
    tick;
    chk4("abort_cas_on", bus.nCAS, 4'b0000);
    idle_bus;
    tick;
    chk_released("abort_rel");
    for (int k = 0; k < 3; k++) begin
      tick;
      chk2("abort_no_dsack", bus.nDSACK, 2'b11);
    end
    start_read(25'h000_1004);
    tick;
    chk2("abort_back_idle", bus.nRAS, 2'b10);

    // Reset asserted while in ACK.
    repeat (4) tick;
    chk2("ack_before_reset", bus.nDSACK, 2'b00);
    #3 nRST = 1'b0;
    #1;
    chk_released("reset_in_ack");
    chk11("reset_in_ack:ma", bus.MA, 11'h000);
    idle_bus;
    @(negedge DRAM_CLK);
    nRST = 1'b1;
    tick;

    // First refresh with the CPU idle.
    wait_cyc(780);
    chk4("rf_not_early", bus.nCAS, 4'b1111);
    tick;
    chk4("rf_cas_first", bus.nCAS, 4'b0000);
    chk2("rf_ras_after_cas", bus.nRAS, 2'b11);
    chk1("rf_we_cas", bus.nWE, 1'b1);
    for (int k = 0; k < 3; k++) begin
      tick;
      chk2("rf_ras_low", bus.nRAS, 2'b00);
      chk4("rf_cas_low", bus.nCAS, 4'b0000);
      chk1("rf_we_high", bus.nWE, 1'b1);
    end
    tick;
    chk_released("rf_rel");

    // Second refresh request coincides with a new access; refresh goes first.
    wait_cyc(1560);
    chk4("rf2_not_early", bus.nCAS, 4'b1111);
    start_read(25'h000_1004);
    tick;
    chk4("rf2_period_cas", bus.nCAS, 4'b0000);
    chk2("rf2_no_access_ras", bus.nRAS, 2'b11);
    tick;
    chk2("rf2_ras_low", bus.nRAS, 2'b00);
    repeat (2) tick;
    for (int k = 0; k < 4; k++) begin
      tick;
      chk2("rf2_access_wait", bus.nRAS, 2'b11);
    end
    tick;
    chk2("rf2_access_ras", bus.nRAS, 2'b10);
    chk11("rf2_access_row", bus.MA, 11'h000);
    repeat (2) tick;
    chk4("rf2_access_cas", bus.nCAS, 4'b0000);
    repeat (2) tick;
    chk2("rf2_access_dsack", bus.nDSACK, 2'b00);
    idle_bus;
    tick;
    chk_released("rf2_access_rel");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
